// File: rtl/risc_pkg.sv
// Shared core types: dmem access sizes, responder FSM states and the store byte-strobe helper.
package risc_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } op_enum_dmem_size;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_LAT_W = 3;

  typedef struct packed {
    logic             wr;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    op_enum_dmem_size size;
    logic             zero_ex;
  } dmem_req_t;

  // Lanes for misaligned shapes wrap or truncate; those requests are rejected before use.
  function automatic logic [3:0] dmem_byte_en(input op_enum_dmem_size size, input logic [1:0] a);
    case (size)
      BYTE:    return 4'b0001 << a;
      HALF:    return 4'b0011 << a;
      WORD:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: combinational read, synchronous byte-enabled write.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Slow-memory dmem slave: one request in flight, LATENCY wait cycles, one-cycle registered response.
// Busy (req_ready=0) from accept until the response cycle ends; held requests are not queued.
module dmem_responder
  import risc_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_wr,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  op_enum_dmem_size req_size,
  input  logic             req_zero_ex,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [DMEM_LAT_W-1:0] LAT_INIT = LATENCY[DMEM_LAT_W-1:0];
  localparam logic [DMEM_LAT_W-1:0] CNT_ONE  = 1;
  localparam bit ZERO_LAT = (LATENCY == 0);

  dmem_state_e           state_q, state_d;
  logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
  dmem_req_t             req_q, req_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  dmem_req_t   req_in, cur;
  logic        accept, do_access, acc_err, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata, shifted, load_val;

  always_comb begin
    req_in.wr      = req_wr;
    req_in.addr    = req_addr;
    req_in.wdata   = req_wdata;
    req_in.size    = req_size;
    req_in.zero_ex = req_zero_ex;
  end

  // With zero latency the access happens on the accept edge, so it must use the live request.
  assign cur = (state_q == IDLE) ? req_in : req_q;

  always_comb begin
    acc_err = 1'b0;
    case (cur.size)
      BYTE:    acc_err = 1'b0;
      HALF:    acc_err = cur.addr[0];
      WORD:    acc_err = (cur.addr[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
    if ({2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS)) acc_err = 1'b1;
  end

  always_comb begin
    ram_wdata = cur.wdata;
    case (cur.size)
      BYTE:    ram_wdata = {4{cur.wdata[7:0]}};
      HALF:    ram_wdata = {2{cur.wdata[15:0]}};
      default: ram_wdata = cur.wdata;
    endcase
  end

  assign ram_be  = dmem_byte_en(cur.size, cur.addr[1:0]);
  assign shifted = ram_rdata >> {cur.addr[1:0], 3'b000};

  always_comb begin
    load_val = shifted;
    case (cur.size)
      BYTE:    load_val = cur.zero_ex ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      HALF:    load_val = cur.zero_ex ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    do_access   = 1'b0;
    req_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (accept) begin
          req_d = req_in;
          cnt_d = LAT_INIT;
          if (ZERO_LAT) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (do_access) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || cur.wr) ? 32'h0 : load_val;
    end
  end

  assign ram_we = do_access && cur.wr && !acc_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (ram_be),
    .idx  (cur.addr[IDX_W+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core: the slave end of the dmem request interface (req/wr/size/zero-extend) driven by the control decoder. Accepts one load or store at a time, and waits a programmable number of cycles to model a slow memory. Applies byte-lane strobes on stores and sign- or zero-extends on loads, then returns a one-cycle response. Sits between the core's load/store path and the on-chip data RAM; the core stalls while `req_ready` is low or a response is pending.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words.
- `LATENCY`, default 1: wait cycles between accept and access, range 0..7.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present (core's dmem_req).
- `req_wr`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_size`  in  op_enum_dmem_size  BYTE=0, HALF=1, WORD=2; 3 is illegal.
- `req_zero_ex`  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- `req_ready`  out  1  responder can accept this cycle.
- `rsp_valid`  out  1  response pulse, exactly one cycle per accepted request.
- `rsp_rdata`  out  32  load result, extended; 0 for stores and errors.
- `rsp_err`  out  1  access rejected (misaligned, out of range, illegal size).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch wr/addr/wdata/size/zero_ex and load the wait counter with LATENCY.
  - Go to WAIT if LATENCY>0, else straight to the access cycle.
- WAIT:
  - `req_ready`=0; counter decrements by one each cycle.
  - When the counter is 1 or below, the access is performed on the next edge.
- Access (the edge entering RESP):
  - Error check: `rsp_err`=1 if size=3, or HALF with addr[0]=1, or WORD with addr[1:0]≠0, or addr[31:2] ≥ DEPTH_WORDS.
  - On error, no RAM write occurs and rdata is 0.
  - Stores: byte enable is 0001<<addr[1:0] for BYTE, 0011<<addr[1:0] for HALF, 1111 for WORD. wdata[7:0] is replicated to all four lanes for BYTE; wdata[15:0] is replicated to both halves for HALF.
  - Loads: read word[addr[31:2]] and shift right by 8·addr[1:0]. Keep 8 or 16 bits, then extend per zero_ex. WORD is passed unchanged.
- RESP:
  - `rsp_valid`=1 for one cycle; `req_ready`=0.
  - Next state is always IDLE.
- A request held on `req_valid` outside IDLE is ignored until IDLE; it is not queued.
- Throughput: one request per LATENCY+2 cycles.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- While `rst`=1, `req_ready`=0; it becomes 1 in the first cycle after deassertion.
- RAM contents are not reset.
- Latency: accept at edge N, `rsp_valid` high in cycle N+1+LATENCY.
- `rsp_rdata` and `rsp_err` are registered and valid only while `rsp_valid`=1. They hold 0 otherwise.
- Store commit happens at the edge entering RESP. A load of the same word accepted afterwards sees the new data.
- Reset during WAIT aborts the request: no write occurs and no response is produced.
- Reset asserted in the same cycle as the commit edge: the write may or may not land; the bench must not check this case.

## Structure
- Add to risc_pkg: `dmem_state_e` {IDLE, WAIT, RESP}; `DMEM_LAT_W`=3; function `dmem_byte_en(size, addr[1:0])` returning a 4-bit strobe.
- The existing `op_enum_dmem_size` is reused unchanged.
- One sub-module, `dmem_ram`:
  - DEPTH_WORDS×32 array with combinational read.
  - Synchronous write with 4-bit byte enable and a word index input.
- The FSM, counter, error check and extension logic stay in `dmem_responder`.

## Test plan
- LATENCY=1: store WORD 0xDEADBEEF @0x10, then load WORD @0x10 → `rsp_valid` 2 cycles after each accept; rdata 0xDEADBEEF; `rsp_err`=0.
- Store BYTE 0x80 @0x13 over 0x00000000, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LW @0x10 → 0x80000000.
- Store HALF 0x1234 @0x22, then LH @0x22 → 0x00001234. Store HALF 0xF00D @0x20, then LH @0x20 → 0xFFFFF00D; LW @0x20 → 0x1234F00D.
- Misaligned LW @0x02, SH @0x01, size=3 @0x00 → `rsp_err`=1, rdata 0. A follow-up LW @0x00 returns the unchanged prior value.
- Out of range: LW @4·DEPTH_WORDS → err=1. LATENCY=0 with back-to-back `req_valid` held high → `req_ready` pattern 1,0,1,0 and one `rsp_valid` per accept.
- LATENCY=3: assert `rst` during WAIT of a store WORD 0xAAAAAAAA @0x40 → no `rsp_valid`; a later LW @0x40 returns the pre-store value.
